// File: rtl/edge_pkg.sv
// Shared edge-select encodings and the mode qualifier for filtered level changes.
package edge_pkg;

  localparam logic [1:0] MODE_RISE = 2'b00;
  localparam logic [1:0] MODE_FALL = 2'b01;
  localparam logic [1:0] MODE_BOTH = 2'b10;
  localparam logic [1:0] MODE_OFF  = 2'b11;

  // Only evaluated on a committed change, so new_lvl alone gives the direction.
  function automatic logic edge_hit(input logic [1:0] mode, input logic new_lvl);
    case (mode)
      MODE_RISE: return new_lvl;
      MODE_FALL: return !new_lvl;
      MODE_BOTH: return 1'b1;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/edge_chan.sv
// One channel: synchroniser, stability filter, filtered level, qualified pulse, sticky flag.
module edge_chan
  import edge_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       x_i,
  input  logic [1:0] mode_i,
  input  logic       clear_i,
  output logic       level_o,
  output logic       pulse_o,
  output logic       sticky_o
);

  localparam int            CW       = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   pulse_q, pulse_d;
  logic                   sticky_q, sticky_d;
  logic                   s, commit;

  if (SYNC_STAGES == 1) begin : g_sync1
    assign sync_d = x_i;
  end else begin : g_syncn
    assign sync_d = {sync_q[SYNC_STAGES-2:0], x_i};
  end

  always_comb begin
    s       = sync_q[SYNC_STAGES-1];
    commit  = (s != level_q) && (cnt_q == CNT_LAST);
    cnt_d   = '0;
    level_d = level_q;
    if (s != level_q) begin
      if (commit) level_d = s;
      else        cnt_d   = cnt_q + 1'b1;
    end
    pulse_d = commit && edge_hit(mode_i, s);
    // A new event outranks a same-cycle clear so it is never lost.
    if (pulse_d)      sticky_d = 1'b1;
    else if (clear_i) sticky_d = 1'b0;
    else              sticky_d = sticky_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      pulse_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      pulse_q  <= pulse_d;
      sticky_q <= sticky_d;
    end
  end

  assign level_o  = level_q;
  assign pulse_o  = pulse_q;
  assign sticky_o = sticky_q;

endmodule

// File: rtl/edge_event_capture.sv
// Multi-channel filtered edge detector with sticky event flags.
module edge_event_capture
  import edge_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] x,
  input  logic [1:0]          mode,
  input  logic [CHANNELS-1:0] clear,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] pulse,
  output logic [CHANNELS-1:0] sticky,
  output logic                any_event
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    edge_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILTER_LEN (FILTER_LEN)
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .x_i     (x[i]),
      .mode_i  (mode),
      .clear_i (clear[i]),
      .level_o (level[i]),
      .pulse_o (pulse[i]),
      .sticky_o(sticky[i])
    );
  end

  assign any_event = |sticky;

endmodule

// File: tb/tb_edge_event_capture.sv
// Directed bench for edge_event_capture (CHANNELS=4, SYNC_STAGES=2, FILTER_LEN=3).
module tb_edge_event_capture;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] x = '0;
  logic [1:0] mode = 2'b00;
  logic [3:0] clear = '0;
  logic [3:0] level, pulse, sticky;
  logic       any_event;

  int n_chk = 0;
  int n_pass = 0;

  edge_event_capture #(.CHANNELS(4), .SYNC_STAGES(2), .FILTER_LEN(3)) dut (
    .clk(clk), .reset(reset), .x(x), .mode(mode), .clear(clear),
    .level(level), .pulse(pulse), .sticky(sticky), .any_event(any_event)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
  endtask

  // Advance one rising edge; inputs are driven and outputs sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Drive channel ch to val right after an edge; level/pulse must move on the 5th edge.
  task automatic run_edge(input int ch, input logic val, input logic exp_pulse);
    x[ch] = val;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("pulse ch%0d k%0d", ch, k), 32'(pulse[ch]), 32'((k == 5) && exp_pulse));
      chk($sformatf("level ch%0d k%0d", ch, k), 32'(level[ch]), 32'((k >= 5) ? val : !val));
    end
  endtask

  initial begin
    do_reset();
    chk("rst level", 32'(level), 32'h0);
    chk("rst pulse", 32'(pulse), 32'h0);
    chk("rst sticky", 32'(sticky), 32'h0);
    chk("rst any", 32'(any_event), 32'h0);

    // basic rise on channel 0
    run_edge(0, 1'b1, 1'b1);
    chk("rise sticky0", 32'(sticky), 32'h1);
    chk("rise any", 32'(any_event), 32'h1);
    clear[0] = 1'b1;
    tick();
    clear[0] = 1'b0;
    chk("clear sticky0", 32'(sticky[0]), 32'h0);
    run_edge(0, 1'b0, 1'b0);
    chk("fall no sticky0", 32'(sticky[0]), 32'h0);

    // 2-cycle glitch on channel 1 is rejected
    x[1] = 1'b1;
    tick();
    tick();
    x[1] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("glitch pulse1", 32'(pulse[1]), 32'h0);
      chk("glitch level1", 32'(level[1]), 32'h0);
    end
    chk("glitch sticky1", 32'(sticky[1]), 32'h0);

    // 3-cycle pulse on channel 1 is accepted, pulse 5 edges after the rise
    x[1] = 1'b1;
    tick();
    tick();
    tick();
    x[1] = 1'b0;
    tick();
    chk("held3 pre pulse1", 32'(pulse[1]), 32'h0);
    tick();
    chk("held3 pulse1", 32'(pulse[1]), 32'h1);
    chk("held3 level1", 32'(level[1]), 32'h1);
    tick();
    chk("held3 pulse1 off", 32'(pulse[1]), 32'h0);
    for (int k = 0; k < 6; k++) tick();
    chk("held3 level1 back", 32'(level[1]), 32'h0);
    clear[1] = 1'b1;
    tick();
    clear[1] = 1'b0;

    // edge-select modes on channel 2 with 8-cycle spacing
    for (int m = 1; m <= 3; m++) begin
      mode = 2'(m);
      run_edge(2, 1'b1, m == 2);
      tick();
      run_edge(2, 1'b0, (m == 1) || (m == 2));
      tick();
      chk($sformatf("mode%0d sticky2", m), 32'(sticky[2]), 32'(m != 3));
      clear[2] = 1'b1;
      tick();
      clear[2] = 1'b0;
    end

    // mode is sampled on the commit edge, not when the input moved
    mode = 2'b11;
    x[2] = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    mode = 2'b10;
    tick();
    chk("late mode pulse2", 32'(pulse[2]), 32'h1);
    mode = 2'b11;
    x[2] = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    chk("off fall pulse2", 32'(pulse[2]), 32'h0);
    mode = 2'b00;
    clear[2] = 1'b1;
    tick();
    clear[2] = 1'b0;
    chk("pre-collision any", 32'(any_event), 32'h0);

    // set/clear collision on channel 3
    x[3] = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    clear[3] = 1'b1;
    tick();
    chk("coll pulse3", 32'(pulse[3]), 32'h1);
    chk("coll sticky3", 32'(sticky[3]), 32'h1);
    tick();
    clear[3] = 1'b0;
    chk("coll2 sticky3", 32'(sticky[3]), 32'h0);
    chk("coll2 any", 32'(any_event), 32'h0);

    // reset mid-filter
    x = '0;
    do_reset();
    x[0] = 1'b1;
    tick();
    chk("midrst pulse a", 32'(pulse), 32'h0);
    tick();
    chk("midrst pulse b", 32'(pulse), 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst level", 32'(level), 32'h0);
    chk("midrst pulse", 32'(pulse), 32'h0);
    chk("midrst sticky", 32'(sticky), 32'h0);
    chk("midrst any", 32'(any_event), 32'h0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("postrst pulse k%0d", k), 32'(pulse), 32'((k == 5) ? 4'h1 : 4'h0));
    end

    // all channels at once
    x = '0;
    do_reset();
    x = 4'b1111;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("all pulse k%0d", k), 32'(pulse), 32'((k == 5) ? 4'hF : 4'h0));
    end
    chk("all sticky", 32'(sticky), 32'hF);
    chk("all level", 32'(level), 32'hF);
    chk("all any", 32'(any_event), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
